// File: rtl/regfile_scoreboard_if.sv
// Register-file / scoreboard bus: write port, two read ports, reserve port and busy status.
// The master side drives requests; the slave side is the register file.
interface regfile_scoreboard_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  logic                  we;
  logic [ADDR_WIDTH-1:0] regsel_dest;
  logic [DATA_WIDTH-1:0] datain;
  logic [ADDR_WIDTH-1:0] regsel_source0;
  logic [ADDR_WIDTH-1:0] regsel_source1;
  logic [DATA_WIDTH-1:0] dataout0;
  logic [DATA_WIDTH-1:0] dataout1;
  logic                  rsv_en;
  logic [ADDR_WIDTH-1:0] rsv_sel;
  logic                  busy0;
  logic                  busy1;
  logic                  rsv_busy;
  logic [ADDR_WIDTH:0]   busy_cnt;

  modport master (
    output we, regsel_dest, datain, regsel_source0, regsel_source1, rsv_en, rsv_sel,
    input  dataout0, dataout1, busy0, busy1, rsv_busy, busy_cnt
  );

  modport slave (
    input  we, regsel_dest, datain, regsel_source0, regsel_source1, rsv_en, rsv_sel,
    output dataout0, dataout1, busy0, busy1, rsv_busy, busy_cnt
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// 2-read/1-write register file with a per-register busy scoreboard and busy counter.
// Define REGFILE_BYPASS_EN to forward same-cycle write data / busy clear to the read ports.
module regfile_scoreboard #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter bit ZERO_REG   = 1'b0
) (
  input logic                 clk,
  input logic                 reset,
  regfile_scoreboard_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_ONE = 1;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]      busy_q, busy_d;
  logic [ADDR_WIDTH:0]   busy_cnt_q, busy_cnt_d;

  logic wr_ok, rsv_ok;
  logic net_set, net_clr;

  // Register 0 swallows writes and reserves when hardwired to zero.
  assign wr_ok  = bus.we     && !(ZERO_REG && (bus.regsel_dest == '0));
  assign rsv_ok = bus.rsv_en && !(ZERO_REG && (bus.rsv_sel == '0));

  always_comb begin
    busy_d = busy_q;
    if (wr_ok)  busy_d[bus.regsel_dest] = 1'b0;
    if (rsv_ok) busy_d[bus.rsv_sel]     = 1'b1;

    // Count tracks net bit transitions; a reserve on the write target wins over the clear.
    net_set = rsv_ok && !busy_q[bus.rsv_sel];
    net_clr = wr_ok && busy_q[bus.regsel_dest] &&
              !(rsv_ok && (bus.rsv_sel == bus.regsel_dest));

    busy_cnt_d = busy_cnt_q;
    if (net_set && !net_clr)      busy_cnt_d = busy_cnt_q + CNT_ONE;
    else if (!net_set && net_clr) busy_cnt_d = busy_cnt_q - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      if (wr_ok) regs_q[bus.regsel_dest] <= bus.datain;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  // Lookup lanes: 0 and 1 are the read ports, 2 is the reserve-port busy probe.
  logic [2:0]            lane_busy;
  logic [DATA_WIDTH-1:0] lane_data [2];

  for (genvar p = 0; p < 3; p++) begin : g_lane
    logic [ADDR_WIDTH-1:0] sel;
    logic                  zero;
    logic                  hit;

    assign sel  = (p == 0) ? bus.regsel_source0 :
                  (p == 1) ? bus.regsel_source1 : bus.rsv_sel;
    assign zero = ZERO_REG && (sel == '0);
    assign hit  = BYPASS && bus.we && (sel == bus.regsel_dest);

    assign lane_busy[p] = zero ? 1'b0 :
                          hit  ? (bus.rsv_en && (bus.rsv_sel == sel)) :
                                 busy_q[sel];

    if (p < 2) begin : g_data
      assign lane_data[p] = zero ? '0 :
                            hit  ? bus.datain :
                                   regs_q[sel];
    end
  end

  assign bus.dataout0 = lane_data[0];
  assign bus.dataout1 = lane_data[1];
  assign bus.busy0    = lane_busy[0];
  assign bus.busy1    = lane_busy[1];
  assign bus.rsv_busy = lane_busy[2];
  assign bus.busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench: two DUTs (ZERO_REG=0 and ZERO_REG=1) share stimulus and are checked
// every cycle against an array-based behavioural model, plus directed literal checks.
module tb_regfile_scoreboard;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int N  = 16;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          we, rsv_en;
  logic [AW-1:0] dest, src0, src1, rsel;
  logic [DW-1:0] din;

  regfile_scoreboard_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_a ();
  regfile_scoreboard_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_b ();

  assign bus_a.we = we;             assign bus_b.we = we;
  assign bus_a.regsel_dest = dest;  assign bus_b.regsel_dest = dest;
  assign bus_a.datain = din;        assign bus_b.datain = din;
  assign bus_a.regsel_source0 = src0; assign bus_b.regsel_source0 = src0;
  assign bus_a.regsel_source1 = src1; assign bus_b.regsel_source1 = src1;
  assign bus_a.rsv_en = rsv_en;     assign bus_b.rsv_en = rsv_en;
  assign bus_a.rsv_sel = rsel;      assign bus_b.rsv_sel = rsel;

  regfile_scoreboard #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1'b0)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  regfile_scoreboard #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1'b1)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: index 0 = ZERO_REG off, index 1 = ZERO_REG on.
  logic [DW-1:0] m_data [2][N];
  bit            m_busy [2][N];
  bit            model_on = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      for (int z = 0; z < 2; z++)
        for (int r = 0; r < N; r++) begin
          m_data[z][r] = '0;
          m_busy[z][r] = 1'b0;
        end
      model_on = 1'b1;
    end else if (model_on) begin
      for (int z = 0; z < 2; z++) begin
        if (we && !(z == 1 && dest == 0)) begin
          m_data[z][dest] = din;
          m_busy[z][dest] = 1'b0;
        end
        if (rsv_en && !(z == 1 && rsel == 0)) m_busy[z][rsel] = 1'b1;
      end
    end
  end

  function automatic logic [DW-1:0] exp_data(input int z, input logic [AW-1:0] sel);
    if (z == 1 && sel == 0) return '0;
    if (BYPASS && we && sel == dest) return din;
    return m_data[z][sel];
  endfunction

  function automatic logic exp_busy(input int z, input logic [AW-1:0] sel);
    if (z == 1 && sel == 0) return 1'b0;
    if (BYPASS && we && sel == dest) return rsv_en && (rsel == sel);
    return m_busy[z][sel];
  endfunction

  function automatic int exp_cnt(input int z);
    int c = 0;
    for (int r = 0; r < N; r++) if (m_busy[z][r]) c++;
    return c;
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_on) begin
      check("a.dataout0", bus_a.dataout0, exp_data(0, src0));
      check("a.dataout1", bus_a.dataout1, exp_data(0, src1));
      check("a.busy0",    bus_a.busy0,    exp_busy(0, src0));
      check("a.busy1",    bus_a.busy1,    exp_busy(0, src1));
      check("a.rsv_busy", bus_a.rsv_busy, exp_busy(0, rsel));
      check("a.busy_cnt", bus_a.busy_cnt, exp_cnt(0));
      check("b.dataout0", bus_b.dataout0, exp_data(1, src0));
      check("b.dataout1", bus_b.dataout1, exp_data(1, src1));
      check("b.busy0",    bus_b.busy0,    exp_busy(1, src0));
      check("b.busy1",    bus_b.busy1,    exp_busy(1, src1));
      check("b.rsv_busy", bus_b.rsv_busy, exp_busy(1, rsel));
      check("b.busy_cnt", bus_b.busy_cnt, exp_cnt(1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; rsv_en = 1'b0;
    dest = '0; src0 = '0; src1 = '0; rsel = '0; din = '0;
    tick(); tick();
    reset = 1'b0;

    // Post-reset: every register reads zero, nothing busy.
    for (int r = 0; r < N; r++) begin
      src0 = AW'(r);
      src1 = AW'(N - 1 - r);
      mid();
      check("rst_dout0", bus_a.dataout0, 0);
      check("rst_dout1", bus_a.dataout1, 0);
      check("rst_busy0", bus_a.busy0, 0);
      check("rst_cnt",   bus_a.busy_cnt, 0);
      tick();
    end

    // Write r5 and read it in the same cycle.
    we = 1'b1; dest = 4'd5; din = 32'hDEADBEEF; src0 = 4'd5;
    mid();
    check("wr5_same", bus_a.dataout0, BYPASS ? 64'hDEADBEEF : 64'h0);
    tick();
    we = 1'b0;
    mid();
    check("wr5_next", bus_a.dataout0, 64'hDEADBEEF);

    // Reserve r3, then write it back.
    rsv_en = 1'b1; rsel = 4'd3; src0 = 4'd3;
    tick();
    rsv_en = 1'b0;
    mid();
    check("rsv3_busy", bus_a.busy0, 1);
    check("rsv3_cnt",  bus_a.busy_cnt, 1);
    we = 1'b1; dest = 4'd3; din = 32'h12;
    tick();
    we = 1'b0;
    mid();
    check("wb3_busy", bus_a.busy0, 0);
    check("wb3_cnt",  bus_a.busy_cnt, 0);
    check("wb3_data", bus_a.dataout0, 64'h12);

    // Reserve and write the same register together: reserve wins, data lands.
    rsv_en = 1'b1; rsel = 4'd7; we = 1'b1; dest = 4'd7; din = 32'h55; src0 = 4'd7;
    tick();
    rsv_en = 1'b0; we = 1'b0;
    mid();
    check("rw7_busy", bus_a.busy0, 1);
    check("rw7_data", bus_a.dataout0, 64'h55);
    check("rw7_cnt",  bus_a.busy_cnt, 1);

    // Fill the scoreboard; counter must saturate at depth without wrapping.
    for (int r = 0; r < N; r++) begin
      rsv_en = 1'b1; rsel = AW'(r);
      tick();
    end
    rsv_en = 1'b0;
    mid();
    check("full_cnt_a", bus_a.busy_cnt, 16);
    check("full_cnt_b", bus_b.busy_cnt, 15);
    rsv_en = 1'b1; rsel = 4'd0;
    tick();
    rsv_en = 1'b0;
    mid();
    check("rersv0_cnt", bus_a.busy_cnt, 16);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mid();
    check("clr_cnt_a", bus_a.busy_cnt, 0);
    check("clr_cnt_b", bus_b.busy_cnt, 0);

    // Register 0 hardwired to zero on dut_b, ordinary on dut_a.
    we = 1'b1; dest = 4'd0; din = 32'hFFFFFFFF; rsv_en = 1'b1; rsel = 4'd0; src0 = 4'd0;
    tick();
    we = 1'b0; rsv_en = 1'b0;
    mid();
    check("zr_b_dout", bus_b.dataout0, 0);
    check("zr_b_busy", bus_b.busy0, 0);
    check("zr_b_cnt",  bus_b.busy_cnt, 0);
    check("zr_a_dout", bus_a.dataout0, 64'hFFFFFFFF);
    check("zr_a_busy", bus_a.busy0, 1);
    check("zr_a_cnt",  bus_a.busy_cnt, 1);

    // Randomised traffic, checked by the per-cycle compare process.
    repeat (3000) begin
      reset  = ($urandom_range(63) == 0);
      we     = $urandom_range(1);
      rsv_en = ($urandom_range(2) == 0);
      dest   = AW'($urandom_range(N - 1));
      rsel   = ($urandom_range(3) == 0) ? dest : AW'($urandom_range(N - 1));
      src0   = ($urandom_range(3) == 0) ? dest : AW'($urandom_range(N - 1));
      src1   = ($urandom_range(3) == 0) ? rsel : AW'($urandom_range(N - 1));
      din    = $urandom;
      tick();
    end
    reset = 1'b0; we = 1'b0; rsv_en = 1'b0;
    mid();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
